// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared defaults, mode constants and length-mask helper for seq_detect_param
package seq_detect_pkg;
  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 16;
  localparam int MASK_W = 64;
  localparam logic MODE_OVERLAP = 1'b1;
  localparam logic MODE_RESTART = 1'b0;
  function automatic logic [MASK_W-1:0] lenmask(input int unsigned n);
    return (MASK_W'(1) << n) - MASK_W'(1);
  endfunction
endpackage

// File: rtl/seq_match_cnt.sv
// seq_match_cnt: saturating event counter with synchronous clear (clear beats increment)
module seq_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  assign cnt = cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-loaded masked serial pattern detector; SEQ_MATCH_CNT_EN adds match_cnt/cnt_clr
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
`ifdef SEQ_MATCH_CNT_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_valid,
  input  logic             x,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
`ifdef SEQ_MATCH_CNT_EN
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             y
);
  logic [PAT_W-1:0] hist_q, hist_d, pat_q, mask_q, lm, hist_sh;
  logic [LEN_W-1:0] fill_q, fill_d, fill_inc, len_q;
  logic             ovl_q, y_q, y_d, len_ok, hit;
  assign lm = PAT_W'(lenmask(32'(len_q)));
  assign hist_sh = {hist_q[PAT_W-2:0], x};
  assign fill_inc = fill_q == LEN_W'(PAT_W) ? fill_q : fill_q + LEN_W'(1);
  assign len_ok = len_q != '0 && len_q <= LEN_W'(PAT_W);
  assign hit = x_valid && len_ok && ((hist_sh ^ pat_q) & mask_q & lm) == '0 && fill_inc >= len_q;
  // next state: a load clears history and drops any bit arriving with it; restart mode refills after a hit
  always_comb begin
    hist_d = cfg_load ? '0 : x_valid ? hist_sh : hist_q;
    fill_d = cfg_load ? '0 : !x_valid ? fill_q : (hit && ovl_q == MODE_RESTART) ? '0 : fill_inc;
    y_d = !cfg_load && hit;
  end
  // state and configuration registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      mask_q <= '0;
      len_q  <= '0;
      ovl_q  <= MODE_RESTART;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      y_q    <= y_d;
      if (cfg_load) begin
        pat_q  <= cfg_pattern;
        mask_q <= cfg_mask;
        len_q  <= cfg_len;
        ovl_q  <= cfg_overlap;
      end
    end
  end
  assign y = y_q;
`ifdef SEQ_MATCH_CNT_EN
  seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk),
    .rst(rst),
    .inc(y_q),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed stimulus, queue-based reference model checked every cycle
module tb_seq_detect_param;
  localparam int PW = 8;
  logic       clk = 1'b0, rst = 1'b1, x_valid = 1'b0, x = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0;
  logic [7:0] cfg_pattern = '0, cfg_mask = '0;
  logic [3:0] cfg_len = '0;
  logic       y;
  int         errs = 0, checks = 0;
  bit         chk_en = 1'b0;
  logic [63:0] got;
`ifdef SEQ_MATCH_CNT_EN
  logic       cnt_clr = 1'b0;
  logic [1:0] match_cnt;
  seq_detect_param #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .match_cnt(match_cnt), .y(y));
`else
  seq_detect_param #(.PAT_W(8), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .x_valid(x_valid), .x(x), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .y(y));
`endif
  always #5 clk = ~clk;

  bit         mq[$];
  logic [7:0] m_pat, m_mask;
  int         m_len = 0, m_cnt = 0;
  bit         m_ovl = 1'b0, m_y = 1'b0;

  function automatic bit m_hit();
    if (m_len < 1 || m_len > PW || mq.size() < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++)
      if (m_mask[i] && mq[mq.size()-1-i] != m_pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pat = '0; m_mask = '0; m_len = 0; m_ovl = 1'b0; m_y = 1'b0; m_cnt = 0;
    end else begin
`ifdef SEQ_MATCH_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (m_y && m_cnt < 3) m_cnt++;
`endif
      m_y = 1'b0;
      if (cfg_load) begin
        m_pat = cfg_pattern; m_mask = cfg_mask; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        mq.delete();
      end else if (x_valid) begin
        mq.push_back(x);
        if (mq.size() > PW) void'(mq.pop_front());
        if (m_hit()) begin
          m_y = 1'b1;
          if (!m_ovl) mq.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("y_vs_model", 64'(y), 64'(m_y));
`ifdef SEQ_MATCH_CNT_EN
    chk("cnt_vs_model", 64'(match_cnt), 64'(m_cnt));
`endif
  end

  task automatic load(input logic [7:0] p, input logic [7:0] m, input logic [3:0] n, input logic o);
    cfg_pattern = p; cfg_mask = m; cfg_len = n; cfg_overlap = o; cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    cfg_pattern = 8'($urandom); cfg_mask = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom);
  endtask

  task automatic feed(input logic [63:0] bits, input int n, input bit gap, output logic [63:0] g);
    g = '0;
    for (int i = 0; i < n; i++) begin
      x = bits[n-1-i]; x_valid = 1'b1;
      @(negedge clk);
      g[n-1-i] = y;
      if (gap) begin
        x_valid = 1'b0;
        @(negedge clk);
      end
    end
    x_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_y", 64'(y), 64'd0);
    chk_en = 1'b1;
    rst = 1'b0;
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    feed(64'b1101101, 7, 1'b0, got);
    chk("overlap_1101", got, 64'b0001001);
    load(8'h0D, 8'hFF, 4'd4, 1'b0);
    feed(64'b1101101, 7, 1'b0, got);
    chk("restart_1101", got, 64'b0001000);
    load(8'hC9, 8'hFF, 4'd8, 1'b1);
    feed(64'({20'hC9094, 20'hC9094}), 40, 1'b0, got);
    chk("len8_periodic", got, (64'd1 << 32) | (64'd1 << 12));
    load(8'h09, 8'h0B, 4'd4, 1'b1);
    feed(64'b10011101, 8, 1'b1, got);
    chk("dontcare_gaps", got, 64'b00010001);
    load(8'h00, 8'h00, 4'd3, 1'b1);
    feed(64'b10110, 5, 1'b0, got);
    chk("mask_zero", got, 64'b00111);
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    feed(64'b110, 3, 1'b0, got);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_y", 64'(y), 64'd0);
    rst = 1'b0;
    feed(64'b1, 1, 1'b0, got);
    chk("rst_mid_last", got, 64'd0);
    load(8'h0D, 8'hFF, 4'd4, 1'b1);
    feed(64'b110, 3, 1'b0, got);
    cfg_pattern = 8'h0D; cfg_mask = 8'hFF; cfg_len = 4'd4; cfg_overlap = 1'b1;
    cfg_load = 1'b1; x_valid = 1'b1; x = 1'b1;
    @(negedge clk);
    chk("load_with_x_y", 64'(y), 64'd0);
    cfg_load = 1'b0; x_valid = 1'b0;
    feed(64'b101, 3, 1'b0, got);
    chk("load_drops_bit", got, 64'd0);
    feed(64'b1101, 4, 1'b0, got);
    chk("after_load_match", got, 64'b0001);
    cfg_pattern = 8'h0D; cfg_mask = 8'hFF; cfg_len = 4'd4; cfg_overlap = 1'b1;
    cfg_load = 1'b1; rst = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0; rst = 1'b0;
    feed(64'b1101, 4, 1'b0, got);
    chk("rst_beats_load", got, 64'd0);
    load(8'h0D, 8'hFF, 4'd0, 1'b1);
    feed(64'b1101101, 7, 1'b0, got);
    chk("len_zero", got, 64'd0);
    load(8'h0D, 8'hFF, 4'd9, 1'b1);
    feed(64'b1101101, 7, 1'b0, got);
    chk("len_over", got, 64'd0);
`ifdef SEQ_MATCH_CNT_EN
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    load(8'h00, 8'h00, 4'd3, 1'b1);
    feed(64'b1010101, 7, 1'b0, got);
    chk("cnt_pulses", got, 64'b0011111);
    @(negedge clk);
    chk("cnt_saturate", 64'(match_cnt), 64'd3);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clear", 64'(match_cnt), 64'd0);
`endif
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
